// File: rtl/multicycle_fsm_controller_if.sv
// multicycle_fsm_controller_if: opcode/run inputs and status/control outputs
// of the multicycle sequencer; slave = controller side, master = driver side.
interface multicycle_fsm_controller_if #(
   parameter int COUNT_WIDTH = 16,
   parameter int STATE_WIDTH = 4
);
   logic [5:0]             opcode;
   logic                   run;
   logic [15:0]            control_word;
   logic [STATE_WIDTH-1:0] state;
   logic                   halted;
   logic                   illegal_op;
   logic [COUNT_WIDTH-1:0] instr_count;

   modport slave (
      input  opcode, run,
      output control_word, state, halted, illegal_op, instr_count
   );

   modport master (
      output opcode, run,
      input  control_word, state, halted, illegal_op, instr_count
   );
endinterface

// File: rtl/multicycle_fsm_controller.sv
// multicycle_fsm_controller: Moore sequencer driving the 16-bit control word.
// Ports: clk, reset (async, active-low), bus (slave): opcode, run in;
// control_word, state, halted, illegal_op, instr_count out.
// Macro ILLEGAL_TRAP_EN: illegal opcode halts instead of acting as a NOP.
module multicycle_fsm_controller #(
   parameter int COUNT_WIDTH = 16,
   parameter int STATE_WIDTH = 4
) (
   input logic                       clk,
   input logic                       reset,
   multicycle_fsm_controller_if.slave bus
);
   typedef logic [STATE_WIDTH-1:0] state_t;

   localparam state_t S_IDLE     = state_t'(0);
   localparam state_t S_FETCH    = state_t'(1);
   localparam state_t S_DECODE   = state_t'(2);
   localparam state_t S_EXEC_R   = state_t'(3);
   localparam state_t S_EXEC_I   = state_t'(4);
   localparam state_t S_ALU_WB   = state_t'(5);
   localparam state_t S_MEM_ADDR = state_t'(6);
   localparam state_t S_MEM_RD   = state_t'(7);
   localparam state_t S_MEM_WB   = state_t'(8);
   localparam state_t S_MEM_WR   = state_t'(9);
   localparam state_t S_BRANCH   = state_t'(10);
   localparam state_t S_JUMP     = state_t'(11);
   localparam state_t S_HALT     = state_t'(12);

   typedef struct packed {
      logic       pc_write_cond;
      logic       pc_write;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic [1:0] alu_src_b;
      logic       alu_src_a;
      logic       reg_write;
      logic       reg_dst;
   } ctrl_t;

   state_t                 state_q;
   state_t                 state_d;
   ctrl_t                  ctrl;
   logic                   op_b4_q;
   logic                   op_b0_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   illegal_q;
   logic                   instr_end;
   logic                   is_r, is_i, is_lw, is_sw;
   logic                   is_bne, is_jmp, is_hlt, is_ill;

   always_comb begin
      is_r   = bus.opcode[5:4] == 2'b00;
      is_i   = bus.opcode[5:4] == 2'b01;
      is_lw  = bus.opcode == 6'b100000;
      is_sw  = bus.opcode == 6'b100001;
      is_bne = bus.opcode == 6'b110000;
      is_jmp = bus.opcode == 6'b110001;
      is_hlt = bus.opcode == 6'b111111;
      is_ill = !(is_r | is_i | is_lw | is_sw | is_bne | is_jmp | is_hlt);
   end

   assign instr_end = (state_q == S_ALU_WB) || (state_q == S_MEM_WB) ||
                      (state_q == S_MEM_WR) || (state_q == S_BRANCH) ||
                      (state_q == S_JUMP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Only opcode bits 4 (R vs I) and 0 (load vs store) are needed later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_b4_q   <= 1'b0;
         op_b0_q   <= 1'b0;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         if (state_q == S_DECODE) begin
            op_b4_q <= bus.opcode[4];
            op_b0_q <= bus.opcode[0];
            if (is_ill) illegal_q <= 1'b1;
         end
         if (instr_end) count_q <= count_q + COUNT_WIDTH'(1);
      end
   end

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:     state_d = bus.run ? S_FETCH : S_IDLE;
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               is_r:          state_d = S_EXEC_R;
               is_i:          state_d = S_EXEC_I;
               is_lw | is_sw: state_d = S_MEM_ADDR;
               is_bne:        state_d = S_BRANCH;
               is_jmp:        state_d = S_JUMP;
               is_hlt:        state_d = S_HALT;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_d = S_HALT;
`else
                  state_d = bus.run ? S_FETCH : S_IDLE;
`endif
               end
            endcase
         end
         S_EXEC_R,
         S_EXEC_I:   state_d = S_ALU_WB;
         S_MEM_ADDR: state_d = op_b0_q ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_d = S_MEM_WB;
         S_ALU_WB,
         S_MEM_WB,
         S_MEM_WR,
         S_BRANCH,
         S_JUMP:     state_d = bus.run ? S_FETCH : S_IDLE;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.ir_write  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.pc_write  = 1'b1;
         end
         S_DECODE:   ctrl.alu_src_b = 2'b10;
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.alu_op    = 2'b11;
         end
         S_ALU_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = ~op_b4_q;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.ior_d    = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.ior_d     = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = 2'b01;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 2'b01;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 2'b10;
         end
         default: ctrl = '0;
      endcase
   end

   assign bus.control_word = ctrl;
   assign bus.state        = state_q;
   assign bus.halted       = state_q == S_HALT;
   assign bus.illegal_op   = illegal_q;
   assign bus.instr_count  = count_q;
endmodule
